// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - shared OTTER opcode/func3 types, pipe states and register-use helpers
package otter_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_OP     = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    F3_PRIV   = 3'd0,
    F3_CSRRW  = 3'd1,
    F3_CSRRS  = 3'd2,
    F3_CSRRC  = 3'd3,
    F3_CSRRWI = 3'd5,
    F3_CSRRSI = 3'd6,
    F3_CSRRCI = 3'd7
  } func3_t;

  typedef enum logic [1:0] {RUN, DRAIN, TRAP} pipe_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

  function automatic logic writes_rd(input logic [31:0] ir);
    logic w;
    w = 1'b0;
    case (ir[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_OP, OP_LOAD: w = 1'b1;
      OP_SYSTEM: w = (ir[14:12] != F3_PRIV);
      default:   w = 1'b0;
    endcase
    return w && (ir[11:7] != 5'd0);
  endfunction

  function automatic logic uses_rs1(input logic [31:0] ir);
    logic u;
    u = 1'b0;
    case (ir[6:0])
      OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP: u = 1'b1;
      // only the register forms of CSR access read rs1; immediate forms use the field as uimm
      OP_SYSTEM: u = (ir[14] == 1'b0) && (ir[13:12] != 2'b00);
      default:   u = 1'b0;
    endcase
    return u;
  endfunction

  function automatic logic uses_rs2(input logic [31:0] ir);
    return (ir[6:0] == OP_OP) || (ir[6:0] == OP_BRANCH) || (ir[6:0] == OP_STORE);
  endfunction

endpackage

// File: rtl/otter_pipe_ctrl_if.sv
// rtl/otter_pipe_ctrl_if.sv - fetch/stage-control bundle between the core datapath and the pipe sequencer
interface otter_pipe_ctrl_if;
  import otter_pkg::*;

  logic [31:0] if_ir;
  logic        if_valid;
  logic        redirect;
  logic        mem_busy;
  logic        int_req;
  logic [31:0] dec_ir;
  logic [31:0] exe_ir;
  logic [31:0] mem_ir;
  logic [31:0] wb_ir;
  logic [3:0]  stage_valid;
  logic        pc_stall;
  fwd_sel_t    fwd_a_sel;
  fwd_sel_t    fwd_b_sel;
  logic        int_taken;

  modport master (
    output if_ir, if_valid, redirect, mem_busy, int_req,
    input  dec_ir, exe_ir, mem_ir, wb_ir, stage_valid, pc_stall, fwd_a_sel, fwd_b_sel, int_taken
  );

  modport slave (
    input  if_ir, if_valid, redirect, mem_busy, int_req,
    output dec_ir, exe_ir, mem_ir, wb_ir, stage_valid, pc_stall, fwd_a_sel, fwd_b_sel, int_taken
  );

endinterface

// File: rtl/otter_hazard_unit.sv
// rtl/otter_hazard_unit.sv - RAW hazard detection and EXE operand forwarding select
module otter_hazard_unit
  import otter_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic [31:0] i_dec_ir,
  input  logic [31:0] i_exe_ir,
  input  logic [31:0] i_mem_ir,
  input  logic [31:0] i_wb_ir,
  input  logic [3:0]  i_valid,
  output logic        o_stall_req,
  output fwd_sel_t    o_fwd_a_sel,
  output fwd_sel_t    o_fwd_b_sel
);

  function automatic logic produces(input logic v, input logic [31:0] ir, input logic [4:0] rs);
    return v && writes_rd(ir) && (ir[11:7] == rs);
  endfunction

  logic [4:0] w_dec_rs1, w_dec_rs2, w_exe_rs1, w_exe_rs2;
  logic       w_dec_use1, w_dec_use2, w_exe_load, w_load_use, w_raw_any;

  assign w_dec_rs1  = i_dec_ir[19:15];
  assign w_dec_rs2  = i_dec_ir[24:20];
  assign w_exe_rs1  = i_exe_ir[19:15];
  assign w_exe_rs2  = i_exe_ir[24:20];
  assign w_dec_use1 = i_valid[0] && uses_rs1(i_dec_ir);
  assign w_dec_use2 = i_valid[0] && uses_rs2(i_dec_ir);
  assign w_exe_load = i_exe_ir[6:0] == OP_LOAD;

  assign w_load_use = w_exe_load &&
                      ((w_dec_use1 && produces(i_valid[1], i_exe_ir, w_dec_rs1)) ||
                       (w_dec_use2 && produces(i_valid[1], i_exe_ir, w_dec_rs2)));

  // WB writes the register file in the same cycle DEC reads it, so only EXE/MEM matter
  assign w_raw_any  = (w_dec_use1 && (produces(i_valid[1], i_exe_ir, w_dec_rs1) ||
                                      produces(i_valid[2], i_mem_ir, w_dec_rs1))) ||
                      (w_dec_use2 && (produces(i_valid[1], i_exe_ir, w_dec_rs2) ||
                                      produces(i_valid[2], i_mem_ir, w_dec_rs2)));

  assign o_stall_req = FWD_EN ? w_load_use : w_raw_any;

  always_comb begin
    o_fwd_a_sel = FWD_RF;
    o_fwd_b_sel = FWD_RF;
    if (FWD_EN && i_valid[1]) begin
      if (uses_rs1(i_exe_ir)) begin
        if (produces(i_valid[2], i_mem_ir, w_exe_rs1))     o_fwd_a_sel = FWD_MEM;
        else if (produces(i_valid[3], i_wb_ir, w_exe_rs1)) o_fwd_a_sel = FWD_WB;
      end
      if (uses_rs2(i_exe_ir)) begin
        if (produces(i_valid[2], i_mem_ir, w_exe_rs2))     o_fwd_b_sel = FWD_MEM;
        else if (produces(i_valid[3], i_wb_ir, w_exe_rs2)) o_fwd_b_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/otter_pipe_ctrl.sv
// rtl/otter_pipe_ctrl.sv - OTTER 5-stage IR chain, stall/flush sequencing and interrupt drain FSM
module otter_pipe_ctrl #(
  parameter int          RESOLVE_STAGE = 0,
  parameter bit          FWD_EN        = 1'b1,
  parameter bit          INT_EN        = 1'b1,
  parameter logic [31:0] NOP_INSN      = otter_pkg::NOP_INSN
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  otter_pipe_ctrl_if.slave  bus
);
  import otter_pkg::*;

  logic [31:0] r_dec_ir, r_exe_ir, r_mem_ir, r_wb_ir;
  logic [3:0]  r_valid;
  pipe_state_t r_state;
  logic        r_int_taken;
  logic        w_stall_req, w_drain;
  fwd_sel_t    w_fwd_a_sel, w_fwd_b_sel;

  otter_hazard_unit #(.FWD_EN(FWD_EN)) u_hazard (
    .i_dec_ir    (r_dec_ir),
    .i_exe_ir    (r_exe_ir),
    .i_mem_ir    (r_mem_ir),
    .i_wb_ir     (r_wb_ir),
    .i_valid     (r_valid),
    .o_stall_req (w_stall_req),
    .o_fwd_a_sel (w_fwd_a_sel),
    .o_fwd_b_sel (w_fwd_b_sel)
  );

  assign w_drain = (r_state == DRAIN);

  // A redirect releases the PC even while draining so the trap returns to the branch target
  assign bus.pc_stall    = bus.mem_busy | (~bus.redirect & (w_stall_req | w_drain));
  assign bus.dec_ir      = r_dec_ir;
  assign bus.exe_ir      = r_exe_ir;
  assign bus.mem_ir      = r_mem_ir;
  assign bus.wb_ir       = r_wb_ir;
  assign bus.stage_valid = r_valid;
  assign bus.fwd_a_sel   = w_fwd_a_sel;
  assign bus.fwd_b_sel   = w_fwd_b_sel;
  assign bus.int_taken   = r_int_taken;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dec_ir    <= NOP_INSN;
      r_exe_ir    <= NOP_INSN;
      r_mem_ir    <= NOP_INSN;
      r_wb_ir     <= NOP_INSN;
      r_valid     <= 4'b0000;
      r_state     <= RUN;
      r_int_taken <= 1'b0;
    end else begin
      if (!bus.mem_busy) begin
        r_wb_ir    <= r_mem_ir;
        r_valid[3] <= r_valid[2];
        r_mem_ir   <= r_exe_ir;
        r_valid[2] <= r_valid[1];
        if (bus.redirect) begin
          if (RESOLVE_STAGE == 1) begin
            r_exe_ir   <= NOP_INSN;
            r_valid[1] <= 1'b0;
          end else begin
            r_exe_ir   <= r_dec_ir;
            r_valid[1] <= r_valid[0];
          end
          r_dec_ir   <= NOP_INSN;
          r_valid[0] <= 1'b0;
        end else if (w_stall_req) begin
          r_exe_ir   <= NOP_INSN;
          r_valid[1] <= 1'b0;
        end else begin
          r_exe_ir   <= r_dec_ir;
          r_valid[1] <= r_valid[0];
          if (w_drain) begin
            r_dec_ir   <= NOP_INSN;
            r_valid[0] <= 1'b0;
          end else begin
            r_dec_ir   <= bus.if_ir;
            r_valid[0] <= bus.if_valid;
          end
        end
      end

      r_int_taken <= 1'b0;
      case (r_state)
        RUN:   if (INT_EN && bus.int_req && !bus.mem_busy) r_state <= DRAIN;
        DRAIN: if (r_valid == 4'b0000) begin
                 r_state     <= TRAP;
                 r_int_taken <= 1'b1;
               end
        TRAP:  r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_pipe_ctrl.sv
// tb/tb_otter_pipe_ctrl.sv - directed bench: three sequencer variants driven by one shared instruction stream
module tb_otter_pipe_ctrl;

  localparam logic [31:0] NOP       = 32'h00000013;
  localparam logic [31:0] ADDI_X1   = 32'h00100093;
  localparam logic [31:0] LW_X5     = 32'h00012283;
  localparam logic [31:0] ADD_X6    = 32'h00128333;
  localparam logic [31:0] ADDI_X3   = 32'h00100193;
  localparam logic [31:0] ADD_X4    = 32'h00318233;
  localparam logic [31:0] ADDI_X0   = 32'h00100013;
  localparam logic [31:0] ADD_X4_X0 = 32'h00000233;
  localparam logic [31:0] BEQ       = 32'h00000063;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  otter_pipe_ctrl_if b0 ();
  otter_pipe_ctrl_if b1 ();
  otter_pipe_ctrl_if b2 ();

  otter_pipe_ctrl #(.RESOLVE_STAGE(0), .FWD_EN(1'b1), .INT_EN(1'b1), .NOP_INSN(NOP))
    u_dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(b0));
  otter_pipe_ctrl #(.RESOLVE_STAGE(1), .FWD_EN(1'b1), .INT_EN(1'b1), .NOP_INSN(NOP))
    u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1));
  otter_pipe_ctrl #(.RESOLVE_STAGE(0), .FWD_EN(1'b0), .INT_EN(1'b1), .NOP_INSN(NOP))
    u_dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(b2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ir, input logic v, input logic rdr,
                       input logic busy, input logic irq);
    b0.if_ir = ir; b0.if_valid = v; b0.redirect = rdr; b0.mem_busy = busy; b0.int_req = irq;
    b1.if_ir = ir; b1.if_valid = v; b1.redirect = rdr; b1.mem_busy = busy; b1.int_req = irq;
    b2.if_ir = ir; b2.if_valid = v; b2.redirect = rdr; b2.mem_busy = busy; b2.int_req = irq;
  endtask

  task automatic step(input logic [31:0] ir, input logic v, input logic rdr,
                      input logic busy, input logic irq);
    drive(ir, v, rdr, busy, irq);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] fill_v [4];
    logic [3:0] drain_v [4];
    fill_v  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    drain_v = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;

    // reset values and pipe fill
    do_reset();
    chk("rst_dec_ir", b0.dec_ir, NOP);
    chk("rst_wb_ir", b0.wb_ir, NOP);
    chk("rst_valid", b0.stage_valid, 4'b0000);
    chk("rst_pc_stall", b0.pc_stall, 1'b0);
    chk("rst_fwd_a", b0.fwd_a_sel, 2'd0);
    chk("rst_int_taken", b0.int_taken, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(ADDI_X1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("fill_valid", b0.stage_valid, fill_v[i]);
    end
    chk("fill_wb_ir", b0.wb_ir, ADDI_X1);

    // load-use: one stall with forwarding, two without
    do_reset();
    step(LW_X5, 1'b1, 1'b0, 1'b0, 1'b0);
    step(ADD_X6, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_stall", b0.pc_stall, 1'b1);
    chk("lu_nofwd_stall1", b2.pc_stall, 1'b1);
    step(ADD_X6, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_bubble_valid", b0.stage_valid, 4'b0101);
    chk("lu_bubble_ir", b0.exe_ir, NOP);
    chk("lu_released", b0.pc_stall, 1'b0);
    chk("lu_nofwd_stall2", b2.pc_stall, 1'b1);
    step(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_exe_ir", b0.exe_ir, ADD_X6);
    chk("lu_fwd_a_wb", b0.fwd_a_sel, 2'd2);
    chk("lu_fwd_b_rf", b0.fwd_b_sel, 2'd0);
    chk("lu_nofwd_valid", b2.stage_valid, 4'b1001);
    chk("lu_nofwd_released", b2.pc_stall, 1'b0);
    step(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_nofwd_exe_ir", b2.exe_ir, ADD_X6);
    chk("lu_nofwd_fwd_a", b2.fwd_a_sel, 2'd0);

    // MEM beats WB; rd = x0 never forwards
    do_reset();
    step(ADDI_X3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(ADDI_X3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(ADD_X4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fp_fwd_a_mem", b0.fwd_a_sel, 2'd1);
    chk("fp_fwd_b_mem", b0.fwd_b_sel, 2'd1);
    chk("fp_no_stall", b0.pc_stall, 1'b0);
    do_reset();
    step(ADDI_X0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(ADDI_X0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(ADD_X4_X0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fp_x0_fwd_a", b0.fwd_a_sel, 2'd0);
    chk("fp_x0_fwd_b", b0.fwd_b_sel, 2'd0);

    // redirect: EXE-resolved flushes DEC and the next EXE, DEC-resolved only DEC
    do_reset();
    step(ADDI_X1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(BEQ, 1'b1, 1'b0, 1'b0, 1'b0);
    step(ADDI_X3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(ADDI_X0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rd1_valid", b1.stage_valid, 4'b1100);
    chk("rd1_dec_ir", b1.dec_ir, NOP);
    chk("rd1_exe_ir", b1.exe_ir, NOP);
    chk("rd1_mem_ir", b1.mem_ir, BEQ);
    chk("rd0_valid", b0.stage_valid, 4'b1110);
    chk("rd0_dec_ir", b0.dec_ir, NOP);
    chk("rd0_exe_ir", b0.exe_ir, ADDI_X3);
    step(ADDI_X1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rd1_next_valid", b1.stage_valid, 4'b1001);
    chk("rd1_next_exe_ir", b1.exe_ir, NOP);

    // MEM_BUSY freezes everything and masks REDIRECT
    do_reset();
    step(ADDI_X1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(BEQ, 1'b1, 1'b0, 1'b0, 1'b0);
    step(ADDI_X3, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(ADDI_X0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("busy_valid", b0.stage_valid, 4'b0111);
      chk("busy_pc_stall", b0.pc_stall, 1'b1);
    end
    chk("busy_dec_ir", b0.dec_ir, ADDI_X3);
    chk("busy_exe_ir", b0.exe_ir, BEQ);
    chk("busy_mem_ir", b0.mem_ir, ADDI_X1);

    // interrupt: one-cycle request with a full pipe
    do_reset();
    for (int i = 0; i < 4; i++) step(ADDI_X1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(ADDI_X1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("int_entry_valid", b0.stage_valid, 4'b1111);
    chk("int_drain_stall", b0.pc_stall, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(ADDI_X1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("int_drain_valid", b0.stage_valid, drain_v[i]);
      chk("int_drain_no_take", b0.int_taken, 1'b0);
    end
    step(ADDI_X1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("int_taken", b0.int_taken, 1'b1);
    chk("int_trap_pc_stall", b0.pc_stall, 1'b0);
    step(ADDI_X1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("int_taken_pulse", b0.int_taken, 1'b0);
    chk("int_resume_valid", b0.stage_valid, 4'b0001);
    chk("int_resume_pc_stall", b0.pc_stall, 1'b0);

    // reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 4; i++) step(ADDI_X1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(ADDI_X1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(ADDI_X1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mid_drain_stall", b0.pc_stall, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", b0.stage_valid, 4'b0000);
    chk("mid_rst_pc_stall", b0.pc_stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("mid_rst_no_take", b0.int_taken, 1'b0);
      chk("mid_rst_run", b0.pc_stall, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
